// File: rtl/mmio_slot_fabric.sv
// AXI4-Lite slave bridging one outstanding bus access at a time onto NUM_SLOTS
// MMIO peripheral slots, with populated-slot mask, fair R/W grant and access watchdog.
module mmio_slot_fabric #(
   parameter int unsigned           NUM_SLOTS      = 16,
   parameter int unsigned           REG_W          = 8,
   parameter logic [NUM_SLOTS-1:0]  SLOT_EN        = {NUM_SLOTS{1'b1}},
   parameter int unsigned           TIMEOUT_CYCLES = 255
) (
   input  logic                      aclk,
   input  logic                      arst_n,
   input  logic [31:0]               S_AXI_awaddr,
   input  logic [2:0]                S_AXI_awprot,
   input  logic                      S_AXI_awvalid,
   output logic                      S_AXI_awready,
   input  logic [31:0]               S_AXI_wdata,
   input  logic [3:0]                S_AXI_wstrb,
   input  logic                      S_AXI_wvalid,
   output logic                      S_AXI_wready,
   output logic [1:0]                S_AXI_bresp,
   output logic                      S_AXI_bvalid,
   input  logic                      S_AXI_bready,
   input  logic [31:0]               S_AXI_araddr,
   input  logic [2:0]                S_AXI_arprot,
   input  logic                      S_AXI_arvalid,
   output logic                      S_AXI_arready,
   output logic [31:0]               S_AXI_rdata,
   output logic [1:0]                S_AXI_rresp,
   output logic                      S_AXI_rvalid,
   input  logic                      S_AXI_rready,
   output logic [NUM_SLOTS-1:0]      slot_chip_select,
   output logic                      read,
   output logic                      write,
   output logic [REG_W-1:0]          reg_addr,
   output logic [31:0]               slot_wr_data,
   input  logic [NUM_SLOTS*32-1:0]   slot_rd_data,
   input  logic [NUM_SLOTS-1:0]      slot_wr_done,
   input  logic [NUM_SLOTS-1:0]      slot_rd_done,
   input  logic [NUM_SLOTS-1:0]      slot_slave_error,
   input  logic [NUM_SLOTS-1:0]      slot_decode_error,
   output logic                      transaction_completed,
   output logic                      busy,
   output logic [15:0]               timeout_count
);

   localparam int unsigned SEL_W = $clog2(NUM_SLOTS);
   localparam int unsigned IDX_W = (SEL_W == 0) ? 1 : SEL_W;
   localparam int unsigned EXT_W = 1 << IDX_W;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Zero-padded so decoded indices beyond NUM_SLOTS read as unpopulated.
   localparam logic [EXT_W-1:0] SLOT_EN_EXT = EXT_W'(SLOT_EN);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;

   state_t            state, state_d;
   logic              last_was_read;
   logic [REG_W-1:0]  reg_addr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [31:0]       wdata_q, rdata_q;
   logic [1:0]        resp_q;
   logic [CNT_W-1:0]  cnt;
   logic [15:0]       tmo_cnt;

   logic              in_idle, grant_wr, grant_rd, slot_ok, strb_ok;
   logic [31:0]       acc_addr;
   logic [IDX_W-1:0]  acc_idx;
   logic              sel_done, timed_out;
   logic [1:0]        sel_resp;
   logic              unused_ok;

   assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot};

   // Readies are gated by reset so nothing is offered while the block is held in reset.
   assign in_idle  = (state == IDLE) && arst_n;
   assign grant_wr = in_idle && S_AXI_awvalid && S_AXI_wvalid && (!S_AXI_arvalid || last_was_read);
   assign grant_rd = in_idle && S_AXI_arvalid && !grant_wr;
   assign acc_addr = grant_wr ? S_AXI_awaddr : S_AXI_araddr;
   assign acc_idx  = IDX_W'((acc_addr >> (REG_W + 2)) & ((32'd1 << SEL_W) - 32'd1));
   assign slot_ok  = SLOT_EN_EXT[acc_idx];
   assign strb_ok  = (S_AXI_wstrb == 4'hF);

   assign sel_done  = (state == WR_ACC) ? slot_wr_done[idx_q] : slot_rd_done[idx_q];
   assign timed_out = !sel_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign sel_resp  = slot_decode_error[idx_q] ? RESP_DECERR :
                      slot_slave_error[idx_q]  ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else         state <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (grant_wr)      state_d = (slot_ok && strb_ok) ? WR_ACC : WR_RESP;
            else if (grant_rd) state_d = slot_ok ? RD_ACC : RD_RESP;
         end
         WR_ACC:  if (sel_done || timed_out) state_d = WR_RESP;
         RD_ACC:  if (sel_done || timed_out) state_d = RD_RESP;
         WR_RESP: if (S_AXI_bready) state_d = IDLE;
         RD_RESP: if (S_AXI_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         last_was_read <= 1'b1;
         reg_addr_q    <= '0;
         idx_q         <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         resp_q        <= RESP_OKAY;
         cnt           <= '0;
         tmo_cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_wr || grant_rd) begin
                  last_was_read <= grant_rd;
                  reg_addr_q    <= acc_addr[REG_W+1:2];
                  idx_q         <= acc_idx;
                  cnt           <= '0;
                  rdata_q       <= '0;
                  if (grant_wr) wdata_q <= S_AXI_wdata;
                  if (!slot_ok)                    resp_q <= RESP_DECERR;
                  else if (grant_wr && !strb_ok)   resp_q <= RESP_SLVERR;
                  else                             resp_q <= RESP_OKAY;
               end
            end
            WR_ACC, RD_ACC: begin
               cnt <= cnt + CNT_W'(1);
               if (sel_done) begin
                  resp_q <= sel_resp;
                  if (state == RD_ACC && sel_resp == RESP_OKAY)
                     rdata_q <= slot_rd_data[32*idx_q +: 32];
               end else if (timed_out) begin
                  resp_q  <= RESP_SLVERR;
                  rdata_q <= '0;
                  if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign S_AXI_awready = grant_wr;
   assign S_AXI_wready  = grant_wr;
   assign S_AXI_arready = grant_rd;
   assign S_AXI_bvalid  = (state == WR_RESP);
   assign S_AXI_bresp   = S_AXI_bvalid ? resp_q : 2'b00;
   assign S_AXI_rvalid  = (state == RD_RESP);
   assign S_AXI_rresp   = S_AXI_rvalid ? resp_q : 2'b00;
   assign S_AXI_rdata   = S_AXI_rvalid ? rdata_q : 32'h0;

   assign write            = (state == WR_ACC);
   assign read             = (state == RD_ACC);
   assign slot_chip_select = (write || read) ? (NUM_SLOTS'(1) << idx_q) : '0;
   assign reg_addr         = reg_addr_q;
   assign slot_wr_data     = wdata_q;

   assign transaction_completed = (S_AXI_bvalid && S_AXI_bready) || (S_AXI_rvalid && S_AXI_rready);
   assign busy                  = (state != IDLE);
   assign timeout_count         = tmo_cnt;

endmodule

// File: tb/tb_mmio_slot_fabric.sv
// Directed bench for mmio_slot_fabric: behavioural slot responder plus
// hand-computed expectations checked with immediate assertions.
module tb_mmio_slot_fabric;

   localparam int              NS  = 16;
   localparam int              RW  = 8;
   localparam logic [NS-1:0]   EN  = 16'hFFDF;
   localparam int              TMO = 8;

   logic               aclk = 1'b0;
   logic               arst_n = 1'b0;
   logic [31:0]        S_AXI_awaddr, S_AXI_wdata, S_AXI_araddr, S_AXI_rdata;
   logic [2:0]         S_AXI_awprot, S_AXI_arprot;
   logic               S_AXI_awvalid, S_AXI_awready, S_AXI_wvalid, S_AXI_wready;
   logic [3:0]         S_AXI_wstrb;
   logic [1:0]         S_AXI_bresp, S_AXI_rresp;
   logic               S_AXI_bvalid, S_AXI_bready, S_AXI_arvalid, S_AXI_arready;
   logic               S_AXI_rvalid, S_AXI_rready;
   logic [NS-1:0]      slot_chip_select;
   logic               read, write;
   logic [RW-1:0]      reg_addr;
   logic [31:0]        slot_wr_data;
   logic [NS*32-1:0]   slot_rd_data;
   logic [NS-1:0]      slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error;
   logic               transaction_completed, busy;
   logic [15:0]        timeout_count;

   always #5 aclk = ~aclk;

   mmio_slot_fabric #(
      .NUM_SLOTS(NS), .REG_W(RW), .SLOT_EN(EN), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .aclk(aclk), .arst_n(arst_n),
      .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awvalid(S_AXI_awvalid),
      .S_AXI_awready(S_AXI_awready),
      .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wvalid(S_AXI_wvalid),
      .S_AXI_wready(S_AXI_wready),
      .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
      .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot), .S_AXI_arvalid(S_AXI_arvalid),
      .S_AXI_arready(S_AXI_arready),
      .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
      .S_AXI_rready(S_AXI_rready),
      .slot_chip_select(slot_chip_select), .read(read), .write(write), .reg_addr(reg_addr),
      .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data),
      .slot_wr_done(slot_wr_done), .slot_rd_done(slot_rd_done),
      .slot_slave_error(slot_slave_error), .slot_decode_error(slot_decode_error),
      .transaction_completed(transaction_completed), .busy(busy), .timeout_count(timeout_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slot responder: the selected slot raises done in the done_at-th cycle of its
   // selection (0 = never); every non-selected slot shows a stray slave error.
   int             done_at       = 0;
   int             sel_cycles    = 0;
   int             strobe_cycles = 0;
   int             tc_cnt        = 0;
   logic [NS-1:0]  cs_seen       = '0;
   logic [RW-1:0]  last_reg_addr = '0;
   logic [31:0]    last_wr_data  = '0;
   logic           fire;

   always @(negedge aclk) begin
      if (slot_chip_select != '0) sel_cycles++;
      else                        sel_cycles = 0;
      fire = (slot_chip_select != '0) && (sel_cycles == done_at);
      slot_wr_done      = (fire && write) ? slot_chip_select : '0;
      slot_rd_done      = (fire && read)  ? slot_chip_select : '0;
      slot_slave_error  = ~slot_chip_select;
      slot_decode_error = '0;
      if (write || read) strobe_cycles++;
      cs_seen |= slot_chip_select;
      if (slot_chip_select != '0) begin
         last_reg_addr = reg_addr;
         last_wr_data  = slot_wr_data;
      end
      if (transaction_completed) tc_cnt++;
   end

   task automatic reset_counters();
      strobe_cycles = 0;
      tc_cnt        = 0;
      cs_seen       = '0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
      bit hs = 0;
      bit got = 0;
      lat  = 0;
      resp = 2'b01;
      @(posedge aclk); #1;
      S_AXI_awaddr = addr; S_AXI_wdata = data; S_AXI_wstrb = strb;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (S_AXI_awready && S_AXI_wready) begin hs = 1; break; end
      end
      check("aw_w_handshake", 64'(hs), 64'd1);
      @(posedge aclk); #1;
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge aclk);
         if (S_AXI_bvalid) begin lat = i; got = 1; break; end
      end
      check("b_valid_seen", 64'(got), 64'd1);
      resp = S_AXI_bresp;
      @(posedge aclk); #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold,
                          output logic [1:0] resp, output logic [31:0] data,
                          output int lat, output int stable_bad);
      bit hs = 0;
      bit got = 0;
      lat = 0; stable_bad = 0; resp = 2'b01; data = '0;
      @(posedge aclk); #1;
      S_AXI_araddr = addr; S_AXI_arvalid = 1'b1; S_AXI_rready = (hold == 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (S_AXI_arready) begin hs = 1; break; end
      end
      check("ar_handshake", 64'(hs), 64'd1);
      @(posedge aclk); #1;
      S_AXI_arvalid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge aclk);
         if (S_AXI_rvalid) begin lat = i; got = 1; break; end
      end
      check("r_valid_seen", 64'(got), 64'd1);
      resp = S_AXI_rresp;
      data = S_AXI_rdata;
      for (int i = 1; i < hold; i++) begin
         @(negedge aclk);
         if (!S_AXI_rvalid || S_AXI_rdata !== data || S_AXI_rresp !== resp || transaction_completed)
            stable_bad++;
      end
      if (hold > 0) begin
         @(posedge aclk); #1;
         S_AXI_rready = 1'b1;
         @(negedge aclk);
         if (!S_AXI_rvalid || S_AXI_rdata !== data || !transaction_completed) stable_bad++;
      end
      @(posedge aclk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat, bad, n, both;
      logic [3:0]  grants;
      bit          hs;

      S_AXI_awaddr = '0; S_AXI_awprot = 3'b010; S_AXI_wdata = '0; S_AXI_wstrb = 4'hF;
      S_AXI_araddr = '0; S_AXI_arprot = 3'b101;
      S_AXI_bready = 1'b1; S_AXI_rready = 1'b1;
      for (int i = 0; i < NS; i++) slot_rd_data[32*i +: 32] = {16'hDEAD, 16'(i)};
      slot_rd_data[32*2 +: 32] = 32'h1234_5678;

      // Reset with every valid raised: nothing may be offered or driven.
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_arvalid = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_ready",  {S_AXI_awready, S_AXI_wready, S_AXI_arready}, 0);
      check("rst_resp",   {S_AXI_bvalid, S_AXI_rvalid, S_AXI_bresp, S_AXI_rresp}, 0);
      check("rst_slot",   {slot_chip_select, read, write}, 0);
      check("rst_rdata",  S_AXI_rdata, 0);
      check("rst_tmo",    timeout_count, 0);
      check("rst_status", {busy, transaction_completed}, 0);
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
      arst_n = 1'b1;

      // Write to slot 1, done in the 4th select cycle.
      done_at = 4; reset_counters();
      do_write(32'h0000_0404, 32'hA5A5_0001, 4'hF, resp, lat);
      check("w1_bresp",    resp, 2'b00);
      check("w1_latency",  64'(lat), 64'd5);
      check("w1_strobes",  64'(strobe_cycles), 64'd4);
      check("w1_cs",       cs_seen, 16'h0002);
      check("w1_reg_addr", last_reg_addr, 8'h01);
      check("w1_wdata",    last_wr_data, 32'hA5A5_0001);
      check("w1_tc",       64'(tc_cnt), 64'd1);
      check("w1_idle",     busy, 1'b0);

      // Read slot 2 with rready held low for 4 cycles.
      done_at = 2; reset_counters();
      do_read(32'h0000_0808, 4, resp, data, lat, bad);
      check("r2_rresp",    resp, 2'b00);
      check("r2_rdata",    data, 32'h1234_5678);
      check("r2_latency",  64'(lat), 64'd3);
      check("r2_stable",   64'(bad), 64'd0);
      check("r2_cs",       cs_seen, 16'h0004);
      check("r2_reg_addr", last_reg_addr, 8'h02);
      check("r2_tc",       64'(tc_cnt), 64'd1);

      // Read of unpopulated slot 5.
      reset_counters();
      do_read(32'h0000_1400, 0, resp, data, lat, bad);
      check("r5_rresp",   resp, 2'b11);
      check("r5_rdata",   data, 32'h0);
      check("r5_latency", 64'(lat), 64'd1);
      check("r5_no_cs",   cs_seen, 16'h0000);
      check("r5_strobes", 64'(strobe_cycles), 64'd0);

      // All valids held together for 4 transactions: grants must alternate starting with write.
      done_at = 1; reset_counters();
      @(posedge aclk); #1;
      S_AXI_awaddr = 32'h0000_0404; S_AXI_wdata = 32'h0BAD_CAFE; S_AXI_wstrb = 4'hF;
      S_AXI_araddr = 32'h0000_0808;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_arvalid = 1'b1;
      n = 0; both = 0; grants = 4'b0000;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge aclk);
         if (S_AXI_awready && S_AXI_arready) both++;
         if (S_AXI_awready)      begin grants[n] = 1'b0; n++; end
         else if (S_AXI_arready) begin grants[n] = 1'b1; n++; end
      end
      @(posedge aclk); #1;
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
      hs = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge aclk);
         if (!busy) begin hs = 1; break; end
      end
      check("arb_count", 64'(n), 64'd4);
      check("arb_order", grants, 4'b1010);
      check("arb_both",  64'(both), 64'd0);
      check("arb_drain", 64'(hs), 64'd1);
      check("arb_tc",    64'(tc_cnt), 64'd4);

      // Write to slot 3 that never completes.
      done_at = 0; reset_counters();
      do_write(32'h0000_0C00, 32'h5555_AAAA, 4'hF, resp, lat);
      check("t3_bresp",   resp, 2'b10);
      check("t3_strobes", 64'(strobe_cycles), 64'd8);
      check("t3_latency", 64'(lat), 64'd9);
      check("t3_cs",      cs_seen, 16'h0008);
      check("t3_tmo_cnt", timeout_count, 16'd1);

      // Partial strobe write: rejected before any slot access.
      done_at = 1; reset_counters();
      do_write(32'h0000_0400, 32'h1111_2222, 4'h3, resp, lat);
      check("s1_bresp",   resp, 2'b10);
      check("s1_strobes", 64'(strobe_cycles), 64'd0);
      check("s1_no_cs",   cs_seen, 16'h0000);
      check("s1_latency", 64'(lat), 64'd1);

      // Reset while a read is in its access phase.
      done_at = 0;
      @(posedge aclk); #1;
      S_AXI_araddr = 32'h0000_0808; S_AXI_arvalid = 1'b1;
      hs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (S_AXI_arready) begin hs = 1; break; end
      end
      @(posedge aclk); #1;
      S_AXI_arvalid = 1'b0;
      @(negedge aclk);
      check("mr_in_access", {hs, read, slot_chip_select}, {1'b1, 1'b1, 16'h0004});
      arst_n = 1'b0;
      #1;
      check("mr_strobes", {read, write, slot_chip_select}, 0);
      check("mr_status",  {busy, S_AXI_rvalid, S_AXI_rdata}, 0);
      check("mr_tmo_cnt", timeout_count, 16'd0);
      repeat (2) @(negedge aclk);
      check("mr_no_resp", {S_AXI_rvalid, S_AXI_bvalid, transaction_completed}, 0);
      arst_n = 1'b1;

      done_at = 2; reset_counters();
      do_read(32'h0000_0808, 0, resp, data, lat, bad);
      check("ar_rresp",   resp, 2'b00);
      check("ar_rdata",   data, 32'h1234_5678);
      check("ar_latency", 64'(lat), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_slot_fabric.md
Name: mmio_slot_fabric

Overview:
- Parametrised AXI4-Lite slave that bridges the main bus to NUM_SLOTS MMIO peripheral slots (timer, gpio, uart, i2c, ...) over the standard slot interface.
- Successor to the fixed 16-slot controller. Adds:
  - configurable slot count and address geometry
  - a populated-slot mask
  - fair read/write arbitration
  - a per-access timeout watchdog
  - strobe checking and error/status reporting
- Sits between the system interconnect and the peripheral slots inside the MMIO subsystem.

Parameters:
- NUM_SLOTS, 16, number of slot ports (1..64).
- REG_W, 8, slot register word-address width.
- SLOT_EN, {NUM_SLOTS{1'b1}}, per-slot populated mask; an unpopulated slot returns DECERR.
- TIMEOUT_CYCLES, 255, access cycles allowed before the block aborts with SLVERR (>=1).

Ports:
- aclk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- S_AXI_awaddr/awprot/awvalid  in  32/3/1;  S_AXI_awready  out  1
- S_AXI_wdata/wstrb/wvalid  in  32/4/1;  S_AXI_wready  out  1
- S_AXI_bresp  out 2;  S_AXI_bvalid  out 1;  S_AXI_bready  in 1
- S_AXI_araddr/arprot/arvalid  in  32/3/1;  S_AXI_arready  out  1
- S_AXI_rdata  out 32;  S_AXI_rresp  out 2;  S_AXI_rvalid  out 1;  S_AXI_rready  in 1
- slot_chip_select  out  NUM_SLOTS  one-hot select of the accessed slot
- read, write  out  1  access strobes, held for the whole access
- reg_addr  out  REG_W  register word address
- slot_wr_data  out  32  write data
- slot_rd_data  in  NUM_SLOTS*32  flattened; slot i occupies bits [32i+31:32i]
- slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error  in  NUM_SLOTS
- transaction_completed  out  1  1-cycle pulse on the B or R handshake
- busy  out  1  state != IDLE
- timeout_count  out  16  saturating count of timed-out accesses

Behaviour:
- Address decode:
  - reg_addr = addr[REG_W+1:2].
  - slot index = addr[REG_W+2+$clog2(NUM_SLOTS)-1 : REG_W+2]. Upper address bits are ignored.
- FSM states: IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP. One transaction is outstanding at a time.
- IDLE acceptance:
  - A write is eligible when awvalid && wvalid.
  - A read is eligible when arvalid.
  - If both are eligible, the grant alternates via the last_was_read flag. Reset value favours write.
  - awready and wready are combinational, asserted together only in IDLE for a granted write. arready is likewise asserted only in IDLE for a granted read.
  - The address, data and index are registered on the handshake.
- Pre-checks at acceptance. A failing check skips the slot access entirely (chip_select stays 0) and goes directly to the response state:
  - Index >= NUM_SLOTS or SLOT_EN[index]==0 -> DECERR (2'b11).
  - Write with wstrb != 4'hF -> SLVERR (2'b10).
- WR_ACC / RD_ACC:
  - chip_select[index] is held at 1, with write or read = 1, until the selected slot's done bit is 1 or the timeout fires.
  - Done beats timeout in the same cycle.
  - Response on done: slot_decode_error -> DECERR; else slot_slave_error -> SLVERR; else OKAY.
  - Read data is captured from the slot lane in the done cycle.
- Timeout:
  - The cycle counter clears on access entry.
  - When it reaches TIMEOUT_CYCLES with no done -> SLVERR, rdata=32'h0, and timeout_count increments, saturating at 16'hFFFF.
- Latency: handshake at cycle 0, strobes from cycle 1. A slot done in cycle k gives bvalid/rvalid in cycle k+1.
- Response states:
  - bvalid/rvalid, resp and rdata are held stable until bready/rready.
  - transaction_completed pulses in the handshake cycle, then the FSM returns to IDLE. The next acceptance is no earlier than the following cycle.
- Errored reads return rdata=32'h0.
- prot is ignored.
- Reset:
  - All outputs are 0, including the ready signals, strobes, chip_select, rdata and timeout_count.
  - The FSM goes to IDLE and last_was_read goes to 1 (so write wins first).
  - A reset mid-access drops the strobes immediately and gives no response.
- Done or error bits from non-selected slots are ignored.

Test Plan:
- Write addr 0x0000_0404, data 0xA5A5_0001, wstrb F; slot 1 asserts wr_done 3 cycles after select -> reg_addr=0x01, chip_select=16'h0002, bvalid 1 cycle after done, bresp=OKAY, one transaction_completed pulse.
- Read addr 0x0000_0808 with slot 2 returning 0x1234_5678 plus rd_done -> rdata=0x1234_5678, rresp=OKAY; rvalid held 4 cycles while rready=0, with rdata stable throughout.
- Read of slot 5 with SLOT_EN[5]=0 -> no chip_select activity, rresp=DECERR, rdata=0.
- Write to slot 3, slot never completes, TIMEOUT_CYCLES=8 -> strobes held for exactly 8 cycles, bresp=SLVERR, timeout_count=1.
- awvalid+wvalid+arvalid all asserted together, back to back for 4 transactions -> grant order W,R,W,R.
- Write with wstrb=4'h3 -> bresp=SLVERR with no slot strobe. Reset asserted during RD_ACC -> all outputs 0 next edge; a following read completes normally.
